// File: rtl/fcvt_sw_issue_ctrl.sv
// Issue sequencer for the shared FCVT.S.W converter: arbitrates requesters, registers the operand,
// and returns the truncated float result two cycles after the grant. Optional macro: FCVT_RR_ARB_EN.
module fcvt_sw_issue_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 6,
  localparam int SRC_W  = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_data,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_nx,
  output logic [SRC_W-1:0]         out_src,
  output logic                     busy
);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t             state;
  logic [31:0]        op_q;
  logic [TAG_W-1:0]   tag_q;
  logic [SRC_W-1:0]   src_q;

  logic               can_issue;
  logic               hs;
  logic [NUM_REQ-1:0] gnt;
  logic [SRC_W-1:0]   gidx;
  logic [31:0]        sel_data;
  logic [TAG_W-1:0]   sel_tag;

  logic [31:0]        mag;
  logic [4:0]         msb;
  logic [30:0]        norm;
  logic [31:0]        cvt_f;
  logic               cvt_nx;

`ifdef FCVT_RR_ARB_EN
  logic [SRC_W-1:0]   rr_ptr;
`endif

  always_comb begin
    gnt       = '0;
    gidx      = '0;
    can_issue = (state == IDLE || (state == DONE && out_ready)) && !flush;
`ifdef FCVT_RR_ARB_EN
    // Search begins one past the last winner so every requester gets a turn.
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (can_issue && gnt == '0 && req_valid[(int'(rr_ptr) + off) % NUM_REQ]) begin
        gnt[(int'(rr_ptr) + off) % NUM_REQ] = 1'b1;
        gidx = SRC_W'((int'(rr_ptr) + off) % NUM_REQ);
      end
    end
`else
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (can_issue && req_valid[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        gidx   = SRC_W'(i);
      end
    end
`endif
  end

  always_comb begin
    sel_data = '0;
    sel_tag  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_data = req_data[32*i +: 32];
        sel_tag  = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign req_ready = gnt;
  assign hs        = |gnt;
  assign busy      = (state != IDLE);

  // Normalising shift puts the leading one at bit 31 (dropped); bits 7:0 are what truncation discards.
  always_comb begin
    mag = op_q[31] ? (~op_q + 32'd1) : op_q;
    msb = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = 5'(i);
    end
    norm   = 31'(mag << (5'd31 - msb));
    cvt_nx = |norm[7:0];
    cvt_f  = (mag == 32'd0) ? 32'd0 : {op_q[31], 8'd127 + {3'd0, msb}, norm[30:8]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
      out_nx    <= 1'b0;
      out_src   <= '0;
      op_q      <= '0;
      tag_q     <= '0;
      src_q     <= '0;
`ifdef FCVT_RR_ARB_EN
      rr_ptr    <= SRC_W'(NUM_REQ - 1);
`endif
    end else begin
      if (flush) begin
        state     <= IDLE;
        out_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: if (hs) state <= CONV;
          CONV: begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= cvt_f;
            out_tag   <= tag_q;
            out_nx    <= cvt_nx;
            out_src   <= src_q;
          end
          DONE: if (out_ready) begin
            out_valid <= 1'b0;
            state     <= hs ? CONV : IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      // hs already excludes flush, so capture needs no extra qualification.
      if (hs) begin
        op_q  <= sel_data;
        tag_q <= sel_tag;
        src_q <= gidx;
`ifdef FCVT_RR_ARB_EN
        rr_ptr <= gidx;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fcvt_sw_issue_ctrl.sv
// Bench for fcvt_sw_issue_ctrl: directed spec vectors, arbitration, backpressure, flush, reset,
// and a randomized run scored against an arithmetic reference model.
module tb_fcvt_sw_issue_ctrl;
  localparam int NR = 2;
  localparam int TW = 6;
  localparam int SW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*32-1:0] req_data;
  logic [NR*TW-1:0] req_tag;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_data;
  logic [TW-1:0]   out_tag;
  logic            out_nx;
  logic [SW-1:0]   out_src;
  logic            busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fcvt_sw_issue_ctrl #(.NUM_REQ(NR), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_tag(req_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_nx(out_nx), .out_src(out_src), .busy(busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d, input logic [TW-1:0] t);
    req_data[32*i +: 32] = d;
    req_tag[TW*i +: TW]  = t;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  // Float value of a signed integer: value = (-1)^s * 2^k * (1 + m/2^23), m truncated.
  function automatic void ref_cvt(input logic [31:0] x, output logic [31:0] f, output logic nx);
    longint v, mag, rem, man;
    int k;
    if (x == 32'd0) begin
      f  = 32'd0;
      nx = 1'b0;
      return;
    end
    v   = longint'($signed(x));
    mag = (v < 0) ? -v : v;
    k   = 0;
    while ((longint'(1) << (k + 1)) <= mag) k++;
    rem = mag - (longint'(1) << k);
    man = (rem * (longint'(1) << 23)) / (longint'(1) << k);
    nx  = ((rem * (longint'(1) << 23)) % (longint'(1) << k)) != 0;
    f   = {x[31], 8'(127 + k), man[22:0]};
  endfunction

  function automatic int exp_grant(input logic [NR-1:0] v, input int last);
`ifdef FCVT_RR_ARB_EN
    for (int off = 1; off <= NR; off++) begin
      if (v[(last + off) % NR]) return (last + off) % NR;
    end
`else
    for (int i = 0; i < NR; i++) begin
      if (v[i]) return i;
    end
`endif
    return -1;
  endfunction

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req_valid = '0; out_ready = 1'b0; req_data = '0; req_tag = '0;
    #3;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 32'd0) begin n_bad++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_cmp++; if (out_tag !== '0 || out_nx !== 1'b0 || out_src !== '0) begin
      n_bad++; $display("FAIL reset_tag_nx_src got %h %b %h want 0 0 0", out_tag, out_nx, out_src); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_idle got busy=%b vld=%b want 0 0", busy, out_valid); end
  endtask

  typedef struct { int src; logic [31:0] d; logic [TW-1:0] t; logic [31:0] f; logic nx; } vec_t;

  task automatic test_directed();
    vec_t vecs[5];
    vecs[0] = '{0, 32'h0000_0005, 6'd3,  32'h40A0_0000, 1'b0};
    vecs[1] = '{1, 32'hFFFF_FFFF, 6'd17, 32'hBF80_0000, 1'b0};
    vecs[2] = '{1, 32'h0000_0000, 6'd33, 32'h0000_0000, 1'b0};
    vecs[3] = '{0, 32'h0100_0001, 6'd44, 32'h4B80_0000, 1'b1};
    vecs[4] = '{1, 32'h8000_0000, 6'd63, 32'hCF00_0000, 1'b0};
    out_ready = 1'b1;
    foreach (vecs[j]) begin
      set_req(vecs[j].src, vecs[j].d, vecs[j].t);
      req_valid = '0;
      req_valid[vecs[j].src] = 1'b1;
      @(negedge clk);
      n_cmp++; if (req_ready !== req_valid) begin
        n_bad++; $display("FAIL dir_grant[%0d] got %b want %b", j, req_ready, req_valid); end
      tick();
      req_valid = '0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
        n_bad++; $display("FAIL dir_conv[%0d] got vld=%b busy=%b want 0 1", j, out_valid, busy); end
      tick();
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== vecs[j].f || out_tag !== vecs[j].t ||
                   out_nx !== vecs[j].nx || out_src !== SW'(vecs[j].src)) begin
        n_bad++; $display("FAIL dir_result[%0d] got vld=%b d=%h t=%0d nx=%b s=%0d want 1 %h %0d %b %0d",
                          j, out_valid, out_data, out_tag, out_nx, out_src,
                          vecs[j].f, vecs[j].t, vecs[j].nx, vecs[j].src); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b1;
    set_req(0, 32'd7, 6'd9);
    req_valid = 2'b01;
    tick();
    set_req(0, 32'd16, 6'd10);
    out_ready = 1'b0;
    tick();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h40E0_0000 || out_tag !== 6'd9 || req_ready !== 2'b00) begin
        n_bad++; $display("FAIL bp_hold[%0d] got vld=%b d=%h t=%0d rdy=%b want 1 40e00000 9 00",
                          c, out_valid, out_data, out_tag, req_ready); end
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_bad++; $display("FAIL bp_regrant got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_conv got vld=%b want 0", out_valid); end
    tick();
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'h4180_0000 || out_tag !== 6'd10) begin
      n_bad++; $display("FAIL bp_second got vld=%b d=%h t=%0d want 1 41800000 10", out_valid, out_data, out_tag); end
    tick();
  endtask

  task automatic test_arbitration();
    int grants[$];
    do_reset();
    set_req(0, 32'd100, 6'd1);
    set_req(1, 32'd200, 6'd2);
    req_valid = 2'b11;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (req_ready == 2'b01) grants.push_back(0);
      else if (req_ready == 2'b10) grants.push_back(1);
      tick();
    end
    req_valid = '0;
    n_cmp++; if (grants.size() != 4) begin n_bad++; $display("FAIL arb_count got %0d want 4", grants.size()); end
    for (int g = 0; g < grants.size() && g < 4; g++) begin
`ifdef FCVT_RR_ARB_EN
      n_cmp++; if (grants[g] != g % 2) begin n_bad++; $display("FAIL arb_seq[%0d] got %0d want %0d", g, grants[g], g % 2); end
`else
      n_cmp++; if (grants[g] != 0) begin n_bad++; $display("FAIL arb_seq[%0d] got %0d want 0", g, grants[g]); end
`endif
    end
    tick(); tick(); tick();
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_req(0, 32'd3, 6'd5);
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++; $display("FAIL flush_conv got busy=%b vld=%b want 0 0", busy, out_valid); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flush_noresult[%0d] got %b want 0", c, out_valid); end
      tick();
    end
    flush = 1'b1;
    req_valid = 2'b01;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b00) begin n_bad++; $display("FAIL flush_nogrant got %b want 00", req_ready); end
    tick();
    flush = 1'b0;
    req_valid = '0;
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL flush_nogrant_busy got %b want 0", busy); end
    // A held result is also dropped by flush.
    out_ready = 1'b0;
    req_valid = 2'b01;
    tick();
    req_valid = '0;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_cmp++; if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_held got vld=%b busy=%b want 0 0", out_valid, busy); end
    out_ready = 1'b1;
  endtask

  task automatic test_rst_midop();
    out_ready = 1'b0;
    set_req(1, 32'h0000_0009, 6'd42);
    req_valid = 2'b10;
    tick();
    req_valid = '0;
    tick();
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'd0 || out_tag !== '0 || out_nx !== 1'b0 ||
                 out_src !== '0 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rst_midop got vld=%b d=%h t=%0d nx=%b s=%0d busy=%b want all 0",
                        out_valid, out_data, out_tag, out_nx, out_src, busy); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_noresult[%0d] got %b want 0", c, out_valid); end
    end
  endtask

  typedef struct { logic [31:0] f; logic nx; logic [TW-1:0] t; int s; } exp_t;

  task automatic test_random();
    exp_t sb[$];
    int   last;
    int   iss_cyc;
    int   g;
    logic exp_vld;
    logic [NR-1:0] exp_rdy;
    logic [31:0] d;
    exp_t e;
    do_reset();
    last = NR - 1;
    iss_cyc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid = NR'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NR; i++) begin
        case ($urandom_range(0, 7))
          0: d = 32'd0;
          1: d = 32'hFFFF_FFFF;
          2: d = 32'h8000_0000;
          3: d = 32'h7FFF_FFFF;
          4: d = 32'h0100_0001;
          default: d = $urandom;
        endcase
        set_req(i, d, TW'($urandom));
      end
      @(negedge clk);
      exp_vld = (sb.size() > 0) && (cyc >= iss_cyc + 2);
      n_cmp++; if (out_valid !== exp_vld) begin
        n_bad++; $display("FAIL rnd_vld[%0d] got %b want %b", cyc, out_valid, exp_vld); end
      if (exp_vld) begin
        n_cmp++; if (out_data !== sb[0].f || out_nx !== sb[0].nx || out_tag !== sb[0].t || out_src !== SW'(sb[0].s)) begin
          n_bad++; $display("FAIL rnd_result[%0d] got d=%h nx=%b t=%0d s=%0d want %h %b %0d %0d",
                            cyc, out_data, out_nx, out_tag, out_src, sb[0].f, sb[0].nx, sb[0].t, sb[0].s); end
      end
      exp_rdy = '0;
      g = -1;
      if (sb.size() == 0 || (exp_vld && out_ready)) begin
        g = exp_grant(req_valid, last);
        if (g >= 0) exp_rdy[g] = 1'b1;
      end
      n_cmp++; if (req_ready !== exp_rdy) begin
        n_bad++; $display("FAIL rnd_grant[%0d] got %b want %b", cyc, req_ready, exp_rdy); end
      if (exp_vld && out_ready) void'(sb.pop_front());
      if (g >= 0) begin
        ref_cvt(req_data[32*g +: 32], e.f, e.nx);
        e.t = req_tag[TW*g +: TW];
        e.s = g;
        sb.push_back(e);
        iss_cyc = cyc;
        last = g;
      end
      tick();
    end
    req_valid = '0;
    out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_arbitration();
    test_flush();
    test_rst_midop();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout got no finish want finish");
    $fatal(1);
  end
endmodule
